// File: rtl/mem32_ctrl.sv
// mem32_ctrl: single-outstanding 32-bit host-to-memory access controller.
// A host request is accepted in IDLE and checked against ADDR_MAX. Legal
// accesses run a one-cycle WRITE strobe, or a one-cycle READ strobe followed
// by a bounded WAIT for mem_valid. Every accepted request ends in RESP. That
// response is held until the host takes it, and is marked as an error for an
// illegal address or for a read timeout.
//
// Handshake rule for both channels: a transfer happens on a rising edge
// where valid and ready are both 1. The producer of a valid holds it and its
// payload stable until that edge. req_ready is 1 only in IDLE, and
// resp_valid is 1 only in RESP.
module mem32_ctrl #(
    parameter int ADDR_MAX = 12,
    parameter int TIMEOUT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic [3:0]  mem_add,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    output logic [7:0]  err_cnt,
    output logic [2:0]  dbg_state_o
);

    localparam int              CW         = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      ADDR_MAX_C = 4'(ADDR_MAX);
    localparam logic [CW-1:0]   TIMEOUT_C  = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    state_e         state_q;
    logic           req_ready_q;
    logic           resp_valid_q;
    logic [31:0]    resp_rdata_q;
    logic           resp_err_q;
    logic           mem_wr_q;
    logic           mem_rd_q;
    logic [3:0]     mem_add_q;
    logic [31:0]    mem_wdata_q;
    logic [CW-1:0]  tmo_q;
    logic [7:0]     err_cnt_q;

    logic [CW-1:0]  tmo_d;
    logic [7:0]     err_cnt_d;

    // Next values of the WAIT cycle counter and the saturating error counter
    always_comb begin
        tmo_d     = tmo_q + 1'b1;
        err_cnt_d = err_cnt_q;
        if (resp_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Controller FSM. Every output is a register updated together with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_add_q    <= 4'd0;
            mem_wdata_q  <= 32'd0;
            tmo_q        <= '0;
            err_cnt_q    <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        mem_add_q   <= req_addr;
                        mem_wdata_q <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (req_addr > ADDR_MAX_C) begin
                            // Illegal address: respond at once, never touch memory
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'd0;
                        end else if (req_we) begin
                            state_q  <= S_WRITE;
                            mem_wr_q <= 1'b1;
                        end else begin
                            state_q  <= S_READ;
                            mem_rd_q <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    mem_wr_q     <= 1'b0;
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'd0;
                end
                S_READ: begin
                    mem_rd_q <= 1'b0;
                    tmo_q    <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_valid) begin
                        // The only place mem_rdata is ever sampled
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= mem_rdata;
                    end else begin
                        tmo_q <= tmo_d;
                        if (tmo_d == TIMEOUT_C) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'd0;
                        end
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        err_cnt_q    <= err_cnt_d;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= 32'd0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    mem_wr_q     <= 1'b0;
                    mem_rd_q     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mem_wr      = mem_wr_q;
    assign mem_rd      = mem_rd_q;
    assign mem_add     = mem_add_q;
    assign mem_wdata   = mem_wdata_q;
    assign err_cnt     = err_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem32_ctrl.sv
// Bench for mem32_ctrl: byte-array memory responder, transaction-level
// latency/response model, per-cycle output compare, directed scenarios.
module tb_mem32_ctrl;

    localparam int ADDR_MAX = 12;
    localparam int TIMEOUT  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_wr, mem_rd;
    logic [3:0]  mem_add;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_valid = 1'b0;
    logic [7:0]  err_cnt;
    logic [2:0]  dbg_state;

    mem32_ctrl #(.ADDR_MAX(ADDR_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_add(mem_add), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .err_cnt(err_cnt), .dbg_state_o(dbg_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    // Byte array; answers a read strobe with mem_valid one cycle later,
    // or never when mem_respond is 0. Idle read data is random garbage.
    logic       mem_respond = 1'b1;
    logic [7:0] mem_b [16];
    logic       mem_inited = 1'b0;
    logic [31:0] mem_word;

    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 16; i++) mem_b[i] = 8'(i * 17);
            mem_inited = 1'b1;
        end
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) mem_b[4'(mem_add + 4'(i))] = mem_wdata[8*i +: 8];
        end
        for (int i = 0; i < 4; i++) mem_word[8*i +: 8] = mem_b[4'(mem_add + 4'(i))];
        if (mem_rd && mem_respond) begin
            mem_valid <= 1'b1;
            mem_rdata <= mem_word;
        end else begin
            mem_valid <= 1'b0;
            mem_rdata <= $urandom;
        end
    end

    // ---------------- transaction model ----------------
    // Tracks the one outstanding request: cycle index since acceptance,
    // the cycle its response must appear, and the response contents.
    logic [7:0]  ref_b [16];
    logic        ref_inited = 1'b0;
    logic        m_busy = 1'b0;
    int          m_k = 0;
    int          m_resp_at = 0;
    logic        m_we = 1'b0;
    logic [3:0]  m_addr = 4'd0;
    logic [31:0] m_wdata = 32'd0;
    logic        m_err = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    int          m_errcnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!ref_inited) begin
            for (int i = 0; i < 16; i++) ref_b[i] = 8'(i * 17);
            ref_inited = 1'b1;
        end
        if (!rst_n) begin
            m_busy   = 1'b0;
            m_k      = 0;
            m_errcnt = 0;
        end else if (m_busy) begin
            if (m_k >= m_resp_at && resp_ready) begin
                m_busy = 1'b0;
                if (m_err && m_errcnt < 255) m_errcnt++;
            end else begin
                m_k++;
            end
        end else if (req_valid) begin
            m_busy  = 1'b1;
            m_k     = 1;
            m_we    = req_we;
            m_addr  = req_addr;
            m_wdata = req_wdata;
            if (int'(req_addr) > ADDR_MAX) begin
                m_resp_at = 1; m_err = 1'b1; m_rdata = 32'd0;
            end else if (req_we) begin
                m_resp_at = 2; m_err = 1'b0; m_rdata = 32'd0;
                for (int i = 0; i < 4; i++) ref_b[4'(req_addr + 4'(i))] = req_wdata[8*i +: 8];
            end else if (mem_respond) begin
                m_resp_at = 3; m_err = 1'b0;
                for (int i = 0; i < 4; i++) m_rdata[8*i +: 8] = ref_b[4'(req_addr + 4'(i))];
            end else begin
                m_resp_at = 2 + TIMEOUT; m_err = 1'b1; m_rdata = 32'd0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic c_inr, c_wr, c_rd, c_rsp;

    always @(negedge clk) begin
        if (rst_n) begin
            c_inr = (int'(m_addr) <= ADDR_MAX);
            c_wr  = m_busy && (m_k == 1) && m_we && c_inr;
            c_rd  = m_busy && (m_k == 1) && !m_we && c_inr;
            c_rsp = m_busy && (m_k >= m_resp_at);
            chk("req_ready", {31'd0, req_ready}, {31'd0, !m_busy});
            chk("mem_wr", {31'd0, mem_wr}, {31'd0, c_wr});
            chk("mem_rd", {31'd0, mem_rd}, {31'd0, c_rd});
            chk("resp_valid", {31'd0, resp_valid}, {31'd0, c_rsp});
            chk("err_cnt", {24'd0, err_cnt}, 32'(m_errcnt));
            if (c_wr) begin
                chk("wr_mem_add", {28'd0, mem_add}, {28'd0, m_addr});
                chk("wr_mem_wdata", mem_wdata, m_wdata);
            end
            if (c_rd) chk("rd_mem_add", {28'd0, mem_add}, {28'd0, m_addr});
            if (c_rsp) begin
                chk("resp_err", {31'd0, resp_err}, {31'd0, m_err});
                chk("resp_rdata", resp_rdata, m_rdata);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge with the controller idle; returns at the falling
    // edge where resp_valid is first seen, with the latency in cycles.
    task automatic run_txn(input logic we, input logic [3:0] a, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic er);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = 4'($urandom); req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
    endtask

    task automatic txn_chk(input string nm, input logic we, input logic [3:0] a,
                           input logic [31:0] wd, input int exp_lat,
                           input logic exp_err, input logic [31:0] exp_rd);
        int lat;
        logic [31:0] rd;
        logic er;
        run_txn(we, a, wd, lat, rd, er);
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_err"}, {31'd0, er}, {31'd0, exp_err});
        chk({nm, "_rdata"}, rd, exp_rd);
        @(negedge clk);
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({nm, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({nm, "_resp_err"}, {31'd0, resp_err}, 32'd0);
        chk({nm, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
        chk({nm, "_mem_rd"}, {31'd0, mem_rd}, 32'd0);
        chk({nm, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({nm, "_mem_add"}, {28'd0, mem_add}, 32'd0);
        chk({nm, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({nm, "_err_cnt"}, {24'd0, err_cnt}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        logic [31:0] rd;
        logic er;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 4'd0; req_wdata = 32'd0;
        resp_ready = 1'b1;
        #1 rst_n = 1'b0;
        #7 check_reset("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Accepted on the first edge after reset release
        txn_chk("wr4", 1'b1, 4'd4, 32'hDEADBEEF, 2, 1'b0, 32'd0);
        txn_chk("rd4", 1'b0, 4'd4, 32'h0, 3, 1'b0, 32'hDEADBEEF);
        txn_chk("wr13", 1'b1, 4'd13, 32'h12345678, 1, 1'b1, 32'd0);
        chk("errcnt_after_wr13", {24'd0, err_cnt}, 32'd1);
        txn_chk("wr12", 1'b1, 4'd12, 32'h01234567, 2, 1'b0, 32'd0);
        txn_chk("rd12", 1'b0, 4'd12, 32'h0, 3, 1'b0, 32'h01234567);
        txn_chk("rd8", 1'b0, 4'd8, 32'h0, 3, 1'b0, 32'hBBAA9988);
        txn_chk("rd15", 1'b0, 4'd15, 32'h0, 1, 1'b1, 32'd0);
        chk("errcnt_after_rd15", {24'd0, err_cnt}, 32'd2);

        // Memory never answers: four WAIT cycles then an error response
        mem_respond = 1'b0;
        txn_chk("rd_timeout", 1'b0, 4'd0, 32'h0, 2 + TIMEOUT, 1'b1, 32'd0);
        chk("errcnt_after_timeout", {24'd0, err_cnt}, 32'd3);
        mem_respond = 1'b1;

        // Host withholds resp_ready for 10 cycles
        resp_ready = 1'b0;
        run_txn(1'b0, 4'd4, 32'h0, lat, rd, er);
        chk("stall_latency", 32'(lat), 32'd3);
        chk("stall_rdata", rd, 32'hDEADBEEF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("stall_rdata_hold", resp_rdata, 32'hDEADBEEF);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("after_stall_req_ready", {31'd0, req_ready}, 32'd1);
        chk("after_stall_resp_valid", {31'd0, resp_valid}, 32'd0);

        // Reset pulse while the read sits in WAIT
        mem_respond = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("wait_rst");
        @(negedge clk);
        chk("wait_rst_no_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        mem_respond = 1'b1;
        rst_n = 1'b1;
        txn_chk("rd12_after_rst", 1'b0, 4'd12, 32'h0, 3, 1'b0, 32'h01234567);
        chk("errcnt_after_rst", {24'd0, err_cnt}, 32'd0);

        // Drive the error counter into saturation
        for (int i = 0; i < 255; i++) begin
            txn_chk("sat_oor", 1'(i), 4'(13 + (i % 3)), 32'(i), 1, 1'b1, 32'd0);
        end
        chk("errcnt_255", {24'd0, err_cnt}, 32'd255);
        txn_chk("sat_oor_last", 1'b1, 4'd14, 32'h0, 1, 1'b1, 32'd0);
        chk("errcnt_saturated", {24'd0, err_cnt}, 32'd255);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound on run time
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
